alu_bist_checker: RTL
=====================

Name: alu_bist_checker

Overview:
- Hardware self-test engine for the 32-bit ALU. It is the driving and checking end of the ALU operand/result interface.
- Generates pseudo-random operand pairs and sweeps all nine SELECT opcodes per pair.
- Waits a settle time, then compares RESULT and ZERO_FLAG against an internal golden model.
- Reports pass/fail, an error count and the first failing vector. Sits beside the ALU in the execute stage for power-on and debug self-test.

Parameters:
- NUM_PAIRS, 64: operand pairs per run; total vectors = 9*NUM_PAIRS; legal range 1..65535.
- SETTLE, 2: cycles between driving a vector and sampling it; legal range 1..255.
- SEED_A, 32'hACE12345: initial LFSR state for operand A; a value of 0 is replaced by 1.
- SEED_B, 32'h1357BEEF: initial LFSR state for operand B; a value of 0 is replaced by 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a run; ignored while busy
- alu_ctrl  out  3  ALU ctrl input; constant 3'b000
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_select  out  4  ALU opcode
- alu_result  in  32  ALU RESULT
- alu_zero  in  1  ALU ZERO_FLAG
- busy  out  1  run in progress
- done  out  1  run complete; held until the next start
- pass  out  1  done and err_count==0
- err_count  out  16  mismatching vectors; saturates at 16'hFFFF
- fail_valid  out  1  first-failure fields below are valid
- fail_select  out  4  opcode of the first failing vector
- fail_a  out  32  operand A of the first failing vector
- fail_b  out  32  operand B of the first failing vector
- fail_result  out  32  alu_result observed on the first failing vector

Behaviour:
- Reset (asynchronous, any state): state=IDLE.
  - All outputs 0: alu_a, alu_b, alu_select, busy, done, pass, err_count, fail_*.
  - LFSRs reloaded from the seeds, op_idx=0, pair_cnt=0.
- Opcode table, op_idx 0..8:
  - 0 ADD 0000, 1 SUB 0001, 2 AND 0010, 3 OR 0100, 4 XOR 0110
  - 5 SLL 1000, 6 SRL 1010, 7 SLT 1100, 8 SLTU 1110
- Operands:
  - alu_a = lfsr_a.
  - For SLL/SRL, alu_b = {26'b0, lfsr_b[5:0]}, which covers shift amounts 0..63.
  - For all other ops, alu_b = lfsr_b.
- LFSR step (Galois, right shift, mask 32'h80200003): next = (x>>1) ^ (x[0] ? 32'h80200003 : 0).
  - Pair 0 uses the seeds unmodified.
  - Both LFSRs step once per pair.
- Golden model (32-bit, wrap on overflow):
  - ADD: A+B. SUB: A-B. AND, OR, XOR: bitwise.
  - SLL: B>=32 ? 0 : A<<B[4:0]. SRL: B>=32 ? 0 : A>>B[4:0], logical.
  - SLT: signed A<B ? 1 : 0. SLTU: unsigned A<B ? 1 : 0.
  - Expected zero flag = (expected==0).
- FSM:
  - IDLE: on start, load seeds, clear err_count, fail_*, done and pass, set busy=1, go to DRIVE.
  - DRIVE: register alu_a, alu_b, alu_select for the current vector; load settle counter with SETTLE; go to WAIT.
  - WAIT: decrement the counter; when it reaches 0, go to CHECK. The ALU inputs are held stable for the whole WAIT.
  - CHECK: mismatch = (alu_result!=expected) | (alu_zero!=expected_zero).
    - On a mismatch, err_count increments (saturating).
    - If fail_valid==0, capture fail_select, fail_a, fail_b, fail_result and set fail_valid=1.
    - Go to NEXT.
  - NEXT:
    - If op_idx<8: op_idx++, go to DRIVE.
    - Otherwise: op_idx=0 and step the LFSRs.
      - If pair_cnt==NUM_PAIRS-1, go to DONE.
      - Else pair_cnt++, go to DRIVE.
  - DONE: busy=0, done=1, pass=(err_count==0). ALU outputs hold the last vector. A start pulse restarts exactly as from IDLE.
- Timing:
  - Each vector takes SETTLE+3 cycles.
  - done rises 1 + 9*NUM_PAIRS*(SETTLE+3) cycles after the start edge.
- start while busy (DRIVE/WAIT/CHECK/NEXT) has no effect.
- Reset asserted mid-run aborts immediately to the reset values above; no partial results are retained.

Test Plan:
- Correct behavioural ALU, NUM_PAIRS=4, SETTLE=2, default seeds, one start pulse -> done=1 and pass=1 exactly 181 cycles later; err_count=0, fail_valid=0, busy=0.
- Faulty ALU that XORs bit 0 into RESULT only for SUB, NUM_PAIRS=4 -> err_count=4, pass=0.
  - fail_select=0001, fail_a=32'hACE12345, fail_b=32'h1357BEEF.
  - fail_result = (32'hACE12345-32'h1357BEEF)^1.
- SEED_A=SEED_B=1, NUM_PAIRS=1, correct ALU except ZERO_FLAG tied 0 -> err_count=5 (SUB, XOR, SRL, SLT, SLTU), fail_select=0001, fail_result=0.
- start pulsed again during WAIT of vector 3 -> ignored; total run length and err_count are unchanged versus the single-start case.
- reset asserted for 1 cycle during pair 2 -> all outputs 0 in the same cycle (asynchronous); a subsequent start gives results identical to a clean run.
- Shift edge checks with a correct ALU: the sampled vector set includes B=32..63 on SLL/SRL with expected 0 -> pass=1. A faulty ALU returning A<<B[4:0] for B>=32 -> err_count>0, fail_select 1000 or 1010.

Source files
------------

// File: rtl/alu_bist_checker.sv
// Built-in self-test engine for the 32-bit ALU: drives LFSR operand pairs through all
// nine opcodes, waits a settle time, and checks RESULT/ZERO_FLAG against a golden model.
module alu_bist_checker #(
  parameter int unsigned NUM_PAIRS = 64,
  parameter int unsigned SETTLE    = 2,
  parameter logic [31:0] SEED_A    = 32'hACE12345,
  parameter logic [31:0] SEED_B    = 32'h1357BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_select,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic        fail_valid,
  output logic [3:0]  fail_select,
  output logic [31:0] fail_a,
  output logic [31:0] fail_b,
  output logic [31:0] fail_result
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SET_W  = 8;

  localparam logic [DATA_W-1:0] LFSR_MASK   = 32'h80200003;
  localparam logic [DATA_W-1:0] SEED_A_EFF  = (SEED_A == '0) ? 32'd1 : SEED_A;
  localparam logic [DATA_W-1:0] SEED_B_EFF  = (SEED_B == '0) ? 32'd1 : SEED_B;
  localparam logic [CNT_W-1:0]  LAST_PAIR   = CNT_W'(NUM_PAIRS - 1);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE);
  localparam logic [3:0]        LAST_OP     = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  lfsr_a, lfsr_a_n, lfsr_b, lfsr_b_n;
  logic [3:0]         op_idx, op_idx_n;
  logic [CNT_W-1:0]   pair_cnt, pair_cnt_n;
  logic [SET_W-1:0]   settle_cnt, settle_cnt_n;
  logic [DATA_W-1:0]  alu_a_n, alu_b_n, fail_a_n, fail_b_n, fail_result_n;
  logic [SEL_W-1:0]   alu_select_n, fail_select_n;
  logic               busy_n, done_n, pass_n, fail_valid_n;
  logic [CNT_W-1:0]   err_count_n;
  logic [DATA_W-1:0]  expected;
  logic               expected_zero, mismatch, start_run;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_MASK : '0);
  endfunction

  function automatic logic [SEL_W-1:0] op_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'b0000;
      4'd1:    return 4'b0001;
      4'd2:    return 4'b0010;
      4'd3:    return 4'b0100;
      4'd4:    return 4'b0110;
      4'd5:    return 4'b1000;
      4'd6:    return 4'b1010;
      4'd7:    return 4'b1100;
      default: return 4'b1110;
    endcase
  endfunction

  // Golden ALU; shift amounts of 32 and above flush to zero.
  function automatic logic [DATA_W-1:0] golden(input logic [SEL_W-1:0] sel,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (sel)
      4'b0000: return DATA_W'(a + b);
      4'b0001: return DATA_W'(a - b);
      4'b0010: return a & b;
      4'b0100: return a | b;
      4'b0110: return a ^ b;
      4'b1000: return (b >= 32'd32) ? '0 : (a << b[4:0]);
      4'b1010: return (b >= 32'd32) ? '0 : (a >> b[4:0]);
      4'b1100: return DATA_W'(($signed(a) < $signed(b)) ? 1 : 0);
      4'b1110: return DATA_W'((a < b) ? 1 : 0);
      default: return '0;
    endcase
  endfunction

  assign alu_ctrl      = 3'b000;
  assign expected      = golden(alu_select, alu_a, alu_b);
  assign expected_zero = (expected == '0);
  assign mismatch      = (alu_result != expected) | (alu_zero != expected_zero);

  always_comb begin
    state_n       = state;
    lfsr_a_n      = lfsr_a;
    lfsr_b_n      = lfsr_b;
    op_idx_n      = op_idx;
    pair_cnt_n    = pair_cnt;
    settle_cnt_n  = settle_cnt;
    alu_a_n       = alu_a;
    alu_b_n       = alu_b;
    alu_select_n  = alu_select;
    busy_n        = busy;
    done_n        = done;
    pass_n        = pass;
    err_count_n   = err_count;
    fail_valid_n  = fail_valid;
    fail_select_n = fail_select;
    fail_a_n      = fail_a;
    fail_b_n      = fail_b;
    fail_result_n = fail_result;
    start_run     = 1'b0;

    case (state)
      S_IDLE: start_run = start;
      S_DRIVE: begin
        alu_a_n      = lfsr_a;
        alu_b_n      = (op_idx == 4'd5 || op_idx == 4'd6) ? {26'b0, lfsr_b[5:0]} : lfsr_b;
        alu_select_n = op_code(op_idx);
        settle_cnt_n = SETTLE_LOAD;
        state_n      = S_WAIT;
      end
      S_WAIT: begin
        settle_cnt_n = settle_cnt - SET_W'(1);
        if (settle_cnt <= SET_W'(1)) state_n = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_count != 16'hFFFF) err_count_n = err_count + CNT_W'(1);
          if (!fail_valid) begin
            fail_valid_n  = 1'b1;
            fail_select_n = alu_select;
            fail_a_n      = alu_a;
            fail_b_n      = alu_b;
            fail_result_n = alu_result;
          end
        end
        state_n = S_NEXT;
      end
      S_NEXT: begin
        if (op_idx < LAST_OP) begin
          op_idx_n = op_idx + 4'd1;
          state_n  = S_DRIVE;
        end else begin
          op_idx_n = 4'd0;
          lfsr_a_n = lfsr_step(lfsr_a);
          lfsr_b_n = lfsr_step(lfsr_b);
          if (pair_cnt == LAST_PAIR) begin
            state_n = S_DONE;
          end else begin
            pair_cnt_n = pair_cnt + CNT_W'(1);
            state_n    = S_DRIVE;
          end
        end
      end
      S_DONE: begin
        busy_n    = 1'b0;
        done_n    = 1'b1;
        pass_n    = (err_count == '0);
        start_run = start;
      end
      default: state_n = S_IDLE;
    endcase

    // A new run restarts identically from IDLE or DONE.
    if (start_run) begin
      lfsr_a_n      = SEED_A_EFF;
      lfsr_b_n      = SEED_B_EFF;
      op_idx_n      = 4'd0;
      pair_cnt_n    = '0;
      err_count_n   = '0;
      fail_valid_n  = 1'b0;
      fail_select_n = '0;
      fail_a_n      = '0;
      fail_b_n      = '0;
      fail_result_n = '0;
      done_n        = 1'b0;
      pass_n        = 1'b0;
      busy_n        = 1'b1;
      state_n       = S_DRIVE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      lfsr_a      <= SEED_A_EFF;
      lfsr_b      <= SEED_B_EFF;
      op_idx      <= 4'd0;
      pair_cnt    <= '0;
      settle_cnt  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_select  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_valid  <= 1'b0;
      fail_select <= '0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_result <= '0;
    end else begin
      state       <= state_n;
      lfsr_a      <= lfsr_a_n;
      lfsr_b      <= lfsr_b_n;
      op_idx      <= op_idx_n;
      pair_cnt    <= pair_cnt_n;
      settle_cnt  <= settle_cnt_n;
      alu_a       <= alu_a_n;
      alu_b       <= alu_b_n;
      alu_select  <= alu_select_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      err_count   <= err_count_n;
      fail_valid  <= fail_valid_n;
      fail_select <= fail_select_n;
      fail_a      <= fail_a_n;
      fail_b      <= fail_b_n;
      fail_result <= fail_result_n;
    end
  end

endmodule
